// File: rtl/code_rx.sv
// code_rx -- serial receiver for 6-bit code words.
//
// Frame: start bit (0), 6 data bits LSB first, stop bit (1), CLKS_PER_BIT
// clocks per bit. The line is double-flopped (rx_s) before use. After the
// falling edge is seen in IDLE (cycle t0), the start bit is confirmed at t0+H,
// data bit k is sampled at t0+H+(k+1)*C and the stop bit at t0+H+7*C.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   rx_in      asynchronous serial line, idle high
//   data_out   last correctly framed word (registered)
//   data_valid one-cycle pulse: data_out just loaded
//   frame_err  one-cycle pulse: frame ended with a 0 stop bit
//   busy       receiver is not in IDLE
module code_rx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [5:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);

   // Down-counter reload values: the sample point is the cycle the counter is 0.
   localparam logic [CW-1:0] H_RELOAD = CW'(H - 1);
   localparam logic [CW-1:0] C_RELOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic          sync1;
   logic          rx_s;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [5:0]    shreg;
   // Set after a framing error so a line stuck low cannot re-trigger a frame;
   // cleared once the line is seen high again in IDLE.
   logic          wait_high;

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= 1'b1;
         rx_s       <= 1'b1;
         state      <= S_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         wait_high  <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sync1      <= rx_in;
         rx_s       <= sync1;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;

         case (state)
            S_IDLE: begin
               if (wait_high) begin
                  if (rx_s) wait_high <= 1'b0;
               end else if (!rx_s) begin
                  state <= S_START;
                  cnt   <= H_RELOAD;
               end
            end

            S_START: begin
               if (cnt == '0) begin
                  if (!rx_s) begin
                     state   <= S_DATA;
                     cnt     <= C_RELOAD;
                     bit_idx <= '0;
                  end else begin
                     // Line went back high before mid-start-bit: glitch.
                     state <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            S_DATA: begin
               if (cnt == '0) begin
                  shreg[bit_idx] <= rx_s;
                  cnt            <= C_RELOAD;
                  if (bit_idx == 3'd5) state <= S_STOP;
                  else                 bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            S_STOP: begin
               if (cnt == '0) begin
                  state <= S_IDLE;
                  if (rx_s) begin
                     data_out   <= shreg;
                     data_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     wait_high <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_code_rx.sv
// Testbench for code_rx: a driver serializes frames onto rx_in and pushes the
// expected response (kind, word, arrival cycle) into a queue; a monitor pops
// and compares whenever the receiver pulses data_valid or frame_err.
module tb_code_rx;

   localparam int C = 4;
   // From line-low at the first edge to the visible pulse: 2 sync flops,
   // half a bit to mid-start, then 7 bit periods to mid-stop, plus register.
   localparam int LAT = 1 + 2 + C / 2 + 7 * C;

   typedef struct {
      bit         err;
      logic [5:0] data;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic [5:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   int         cyc = 0;
   int         ntests = 0;
   int         nfail = 0;
   exp_t       exp_q[$];
   logic [5:0] last_good = '0;

   code_rx #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in),
      .data_out(data_out), .data_valid(data_valid),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst && (data_valid || frame_err)) begin
         if (data_valid && frame_err) begin
            check("both_pulses", 1, 0);
         end else if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, data_valid, frame_err}, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pulse_kind_err", int'(frame_err), int'(e.err));
            check("pulse_cycle", cyc, e.cyc);
            check("data_out", int'(data_out), e.err ? int'(last_good) : int'(e.data));
            if (!e.err) last_good = e.data;
         end
      end
   end

   task automatic drive_bit(input bit b);
      rx_in = b;
      repeat (C) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge right after the stop bit.
   task automatic send_frame(input logic [5:0] d, input bit stop, input bit expect_resp);
      exp_t e;
      if (expect_resp) begin
         e.err  = !stop;
         e.data = d;
         e.cyc  = cyc + LAT;
         exp_q.push_back(e);
      end
      drive_bit(1'b0);
      for (int k = 0; k < 6; k++) drive_bit(d[k]);
      drive_bit(stop);
      rx_in = 1'b1;
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_outs_zero(input string tag);
      check({tag, "_data_out"}, int'(data_out), 0);
      check({tag, "_data_valid"}, int'(data_valid), 0);
      check({tag, "_frame_err"}, int'(frame_err), 0);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      int base;
      int budget;
      logic [5:0] d;
      bit stop;

      // Reset state
      repeat (3) @(negedge clk);
      check_outs_zero("reset");
      rst = 1'b0;

      // First frame immediately after reset release
      send_frame(6'b101010, 1'b1, 1'b1);
      idle(4);
      check("busy_after_frame", int'(busy), 0);
      check("data_out_hold", int'(data_out), 6'b101010);

      // Back-to-back pair
      send_frame(6'b101111, 1'b1, 1'b1);
      send_frame(6'b011011, 1'b1, 1'b1);
      idle(6);

      // Bad stop bit: error pulse, data_out retained
      send_frame(6'b101100, 1'b0, 1'b1);
      idle(6);
      check("data_out_after_err", int'(data_out), 6'b011011);

      // One-cycle glitch on the line
      base = cyc;
      rx_in = 1'b0;
      @(negedge clk);
      rx_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("glitch_busy_hi", int'(busy), 1);
      repeat (4) @(negedge clk);
      check("glitch_busy_lo", int'(busy), 0);
      idle(4);

      // Reset during data bit 3
      d = 6'b101101;
      drive_bit(1'b0);
      for (int k = 0; k < 3; k++) drive_bit(d[k]);
      rx_in = d[3];
      repeat (2) @(negedge clk);
      rst = 1'b1;
      rx_in = 1'b1;
      @(negedge clk);
      check_outs_zero("midframe_rst");
      last_good = '0;
      rst = 1'b0;
      idle(3);
      send_frame(6'b110010, 1'b1, 1'b1);
      idle(4);

      // Line held low for 20 bit periods: one framing error only
      begin
         exp_t e;
         e.err = 1'b1; e.data = '0; e.cyc = cyc + LAT;
         exp_q.push_back(e);
      end
      rx_in = 1'b0;
      repeat (20 * C) @(negedge clk);
      check("stuck_low_busy", int'(busy), 0);
      idle(3 * C);
      check("stuck_low_recover_busy", int'(busy), 0);
      send_frame(6'b000111, 1'b1, 1'b1);
      idle(2);

      // Randomized frames, stop bits and gaps (gap 0 = back-to-back)
      for (int i = 0; i < 30; i++) begin
         d    = 6'($urandom_range(0, 63));
         stop = ($urandom_range(0, 3) != 0);
         send_frame(d, stop, 1'b1);
         if (!stop) idle(2 + $urandom_range(0, 4));
         else       idle($urandom_range(0, 4));
      end

      // Drain the scoreboard with a bounded wait
      budget = 0;
      while (exp_q.size() != 0 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      check("scoreboard_drained", exp_q.size(), 0);
      idle(10);
      check("final_busy", int'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
